// File: rtl/traffic_pkg.sv
// traffic_pkg: shared phase encoding and lamp codes for the traffic sequencer
package traffic_pkg;
  typedef enum logic [1:0] {GREEN, YELLOW, ALL_RED, PREEMPT} phase_e;
  localparam logic [2:0] LIGHT_GREEN = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED = 3'b100;
endpackage

// File: rtl/rr_dir_select.sv
// rr_dir_select: next direction with demand after cur_dir, cur_dir checked last; plain +1 when idle
module rr_dir_select #(
  parameter int N_DIR = 4,
  localparam int DIR_W = $clog2(N_DIR)
) (
  input logic [N_DIR-1:0] demand,
  input logic [DIR_W-1:0] cur_dir,
  output logic [DIR_W-1:0] next_dir
);
  logic [DIR_W-1:0] idx;
  always_comb begin
    idx = '0;
    next_dir = DIR_W'((int'(cur_dir) + 1) % N_DIR);
    for (int k = N_DIR; k >= 1; k--) begin
      idx = DIR_W'((int'(cur_dir) + k) % N_DIR);
      if (demand[idx]) next_dir = idx;
    end
  end
endmodule

// File: rtl/traffic_controller_param.sv
// traffic_controller_param: N-way green/yellow/all-red sequencer with demand skipping
// and latched emergency pre-emption; all outputs registered.
module traffic_controller_param
  import traffic_pkg::*;
#(
  parameter int N_DIR = 4,
  parameter int GREEN_CYC = 10,
  parameter int YELLOW_CYC = 5,
  parameter int ALLRED_CYC = 2,
  parameter int CNT_W = 8,
  localparam int DIR_W = $clog2(N_DIR)
) (
  input logic clk,
  input logic reset,
  input logic tick_en,
  input logic [N_DIR-1:0] demand,
  input logic preempt_req,
  input logic [DIR_W-1:0] preempt_dir,
  output logic [3*N_DIR-1:0] light,
  output logic [DIR_W-1:0] active_dir,
  output logic [1:0] phase,
  output logic preempt_ack
);
  localparam int MAX_DUR = GREEN_CYC > YELLOW_CYC ? (GREEN_CYC > ALLRED_CYC ? GREEN_CYC : ALLRED_CYC)
                                                  : (YELLOW_CYC > ALLRED_CYC ? YELLOW_CYC : ALLRED_CYC);
  if ((2 ** CNT_W) < MAX_DUR) begin : g_cnt_chk
    $error("CNT_W too narrow for the longest phase duration");
  end
  phase_e st, nst;
  logic [CNT_W-1:0] cnt, dur_m1;
  logic pl, acc, pl_eff, done;
  logic [DIR_W-1:0] pd, pd_eff, rr_dir, ndir;
  logic [3*N_DIR-1:0] nlight;
  rr_dir_select #(.N_DIR(N_DIR)) u_rr (.demand(demand), .cur_dir(active_dir), .next_dir(rr_dir));
  assign phase = st;
  // A request arriving on the all-red timeout edge is honoured immediately
  always_comb begin
    acc = preempt_req && !pl && st != PREEMPT;
    pl_eff = pl || acc;
    pd_eff = acc ? preempt_dir : pd;
    dur_m1 = st == GREEN ? CNT_W'(GREEN_CYC - 1) : st == YELLOW ? CNT_W'(YELLOW_CYC - 1) : CNT_W'(ALLRED_CYC - 1);
    done = tick_en && cnt == dur_m1;
    nst = st;
    ndir = active_dir;
    case (st)
      GREEN: nst = acc ? (preempt_dir == active_dir ? PREEMPT : YELLOW) : done ? YELLOW : GREEN;
      YELLOW: nst = done ? ALL_RED : YELLOW;
      ALL_RED: begin
        nst = done ? (pl_eff ? PREEMPT : GREEN) : ALL_RED;
        ndir = done ? (pl_eff ? pd_eff : rr_dir) : active_dir;
      end
      default: nst = preempt_req ? PREEMPT : YELLOW;
    endcase
    nlight = {N_DIR{LIGHT_RED}};
    if (nst != ALL_RED) nlight[3*ndir+:3] = nst == YELLOW ? LIGHT_YELLOW : LIGHT_GREEN;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= ALL_RED;
      active_dir <= DIR_W'(N_DIR - 1);
      cnt <= '0;
      pl <= 1'b0;
      pd <= '0;
      light <= {N_DIR{LIGHT_RED}};
      preempt_ack <= 1'b0;
    end else begin
      st <= nst;
      active_dir <= ndir;
      cnt <= nst != st ? '0 : cnt + CNT_W'(tick_en && st != PREEMPT);
      pl <= nst == PREEMPT ? 1'b0 : pl_eff;
      if (acc) pd <= preempt_dir;
      light <= nlight;
      preempt_ack <= nst == PREEMPT;
    end
  end
endmodule
